// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle of the shift-add multiplier: operands and start in, product and status out.
// Handshake: start is taken only on an edge while ready=1; ack is taken only on an edge while valid=1.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   input1;
  logic [WIDTH-1:0]   input2;
  logic               ready;
  logic               busy;
  logic               valid;
  logic               ack;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, input1, input2, ack,
    input  ready, busy, valid, product
  );

  modport slave (
    input  start, input1, input2, ack,
    output ready, busy, valid, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-add step per clock through a ripple-carry adder.
// Optional macro EARLY_TERMINATE_EN ends the calculation once the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus,
  output logic [1:0]            o_dbg_state
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_acc;

  logic [WIDTH-1:0] w_mplier_shift;
  logic             w_step_last;
  logic             w_ready;
  logic             w_busy;
  logic             w_valid;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_carry;

  assign w_mplier_shift = r_mplier >> 1;
  assign w_addend       = r_mplier[0] ? r_mcand : '0;

`ifdef EARLY_TERMINATE_EN
  assign w_step_last = (r_count == LAST) || (w_mplier_shift == '0);
`else
  assign w_step_last = (r_count == LAST);
`endif

  // Ripple-carry chain of full-adder cells; the top carry-out is never needed.
  assign w_carry[0] = 1'b0;
  for (genvar gi = 0; gi < PW; gi++) begin : g_fa
    assign w_sum[gi] = r_acc[gi] ^ w_addend[gi] ^ w_carry[gi];
    if (gi < PW - 1) begin : g_cout
      assign w_carry[gi+1] = (r_acc[gi] & w_addend[gi]) |
                             (w_carry[gi] & (r_acc[gi] ^ w_addend[gi]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_state_next = S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_step_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_valid = 1'b1;
        if (bus.ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.input1};
            r_mplier <= bus.input2;
            r_count  <= '0;
            r_acc    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shift;
          r_count  <= r_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = w_ready;
  assign bus.busy    = w_busy;
  assign bus.valid   = w_valid;
  assign bus.product = r_acc;
  assign o_dbg_state = r_state;
endmodule
